// File: rtl/enc_pkg.sv
// Shared types and width-generic helpers for the round-robin priority encoder.
// Functions work on a vector zero-extended to MAX_N bits, so one body serves every N.
package enc_pkg;

    typedef enum logic {
        ENC_FIXED = 1'b0,
        ENC_RR    = 1'b1
    } mode_e;

    localparam int MAX_N = 256;
    localparam int MAX_W = 8;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic popcount_gt1(input logic [MAX_N-1:0] v);
        return |(v & (v - MAX_N'(1)));
    endfunction

    // Offset of the lowest set bit of an already-rotated vector; 0 when empty.
    function automatic logic [MAX_W-1:0] rot_lowest_set(input logic [MAX_N-1:0] v);
        logic [MAX_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i] && !found) begin
                idx   = MAX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_search.sv
// Combinational circular search: first set bit of req at or after start, wrapping at N-1.
// Rotating right by start turns the circular search into a plain lowest-bit search.
module prio_search
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         none
);

    logic [N-1:0] rotated;
    logic [W-1:0] low;
    logic [W:0]   sum;

    always_comb begin
        rotated = (req >> start) | (req << (N - int'(start)));
        none    = ~|req;
        low     = W'(rot_lowest_set(MAX_N'(rotated)));
        sum     = {1'b0, start} + {1'b0, low};
        // start and low are each below N, so a single subtraction brings the sum back in range.
        if (sum >= (W+1)'(N)) begin
            sum = sum - (W+1)'(N);
        end
        idx = none ? '0 : sum[W-1:0];
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder with fixed or round-robin search,
// explicit all-zero / multi-hot flags and a single pass-through output register.
module prio_encoder_rr
    import enc_pkg::*;
#(
    parameter int  N       = 8,
    parameter int  RR_MODE = 0,
    localparam int W       = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_req,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_none,
    output logic         out_multi
);

    localparam mode_e MODE = (RR_MODE != 0) ? ENC_RR : ENC_FIXED;

    logic [W-1:0] ptr;
    logic [W-1:0] start;
    logic [W-1:0] sel_idx;
    logic         sel_none;
    logic         sel_multi;
    logic         xfer_in;
    logic         xfer_out;

    // Handshake: a beat moves on each side when valid && ready at the rising edge.
    // in_ready depends only on out_valid and out_ready, so a held result frees the
    // register in the same cycle the consumer takes it and a new vector may load then.
    assign in_ready = !out_valid || out_ready;
    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = out_valid && out_ready;

    assign start     = (MODE == ENC_RR) ? ptr : '0;
    assign sel_multi = popcount_gt1(MAX_N'(in_req));

    prio_search #(
        .N (N),
        .W (W)
    ) u_search (
        .req   (in_req),
        .start (start),
        .idx   (sel_idx),
        .none  (sel_none)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_none  <= 1'b0;
            out_multi <= 1'b0;
        end else if (xfer_in) begin
            out_valid <= 1'b1;
            out_idx   <= sel_idx;
            out_none  <= sel_none;
            out_multi <= sel_multi;
        end else if (xfer_out) begin
            out_valid <= 1'b0;
        end
    end

    // Pointer moves past the winner only when something actually won.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (MODE == ENC_RR && xfer_in && !sel_none) begin
            ptr <= (sel_idx == W'(N-1)) ? '0 : sel_idx + W'(1);
        end
    end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: three instances (N=8 fixed, N=8 round-robin, N=5 round-robin)
// driven with directed vectors; expected {none, multi, idx} tuples go through per-instance queues.
module tb_prio_encoder_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // instance a: N=8 fixed
    logic       in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b0;
    logic [7:0] in_req_a = '0;
    logic [2:0] out_idx_a;
    logic       out_none_a, out_multi_a;
    // instance b: N=8 round-robin
    logic       in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
    logic [7:0] in_req_b = '0;
    logic [2:0] out_idx_b;
    logic       out_none_b, out_multi_b;
    // instance c: N=5 round-robin
    logic       in_valid_c = 1'b0, in_ready_c, out_valid_c, out_ready_c = 1'b1;
    logic [4:0] in_req_c = '0;
    logic [2:0] out_idx_c;
    logic       out_none_c, out_multi_c;

    prio_encoder_rr #(.N(8), .RR_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_req(in_req_a), .in_ready(in_ready_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_idx(out_idx_a),
        .out_none(out_none_a), .out_multi(out_multi_a)
    );
    prio_encoder_rr #(.N(8), .RR_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_req(in_req_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_idx(out_idx_b),
        .out_none(out_none_b), .out_multi(out_multi_b)
    );
    prio_encoder_rr #(.N(5), .RR_MODE(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_req(in_req_c), .in_ready(in_ready_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .out_idx(out_idx_c),
        .out_none(out_none_c), .out_multi(out_multi_c)
    );

    int checks = 0;
    int errors = 0;

    // expected tuple: {none, multi, idx[2:0]}
    logic [4:0] exp_a[$];
    logic [4:0] exp_b[$];
    logic [4:0] exp_c[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready_a) begin
            if (exp_a.size() == 0) fail_now("a_unexpected_output");
            else check("a_out", {27'b0, out_none_a, out_multi_a, out_idx_a}, {27'b0, exp_a.pop_front()});
        end
        if (!rst && out_valid_b && out_ready_b) begin
            if (exp_b.size() == 0) fail_now("b_unexpected_output");
            else check("b_out", {27'b0, out_none_b, out_multi_b, out_idx_b}, {27'b0, exp_b.pop_front()});
        end
        if (!rst && out_valid_c && out_ready_c) begin
            check("c_idx_range", {31'b0, out_idx_c < 3'd5}, 32'd1);
            if (exp_c.size() == 0) fail_now("c_unexpected_output");
            else check("c_out", {27'b0, out_none_c, out_multi_c, out_idx_c}, {27'b0, exp_c.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input int dut, input logic v, input logic [7:0] req);
        case (dut)
            0:       begin in_valid_a = v; in_req_a = req;      end
            1:       begin in_valid_b = v; in_req_b = req;      end
            default: begin in_valid_c = v; in_req_c = req[4:0]; end
        endcase
    endtask

    function automatic logic ready_of(input int dut);
        case (dut)
            0:       return in_ready_a;
            1:       return in_ready_b;
            default: return in_ready_c;
        endcase
    endfunction

    task automatic push_exp(input int dut, input logic [4:0] e);
        case (dut)
            0:       exp_a.push_back(e);
            1:       exp_b.push_back(e);
            default: exp_c.push_back(e);
        endcase
    endtask

    // Present one vector; returns #1 after the accepting edge.
    task automatic send(input int dut, input logic [7:0] req, input logic [4:0] e);
        logic took;
        took = 1'b0;
        set_in(dut, 1'b1, req);
        for (int g = 0; g < 50 && !took; g++) begin
            @(negedge clk);
            took = ready_of(dut);
            if (took) push_exp(dut, e);
            @(posedge clk);
            #1;
        end
        set_in(dut, 1'b0, req);
        if (!took) fail_now("send_timeout");
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] one;
        int         c0;
        one = 8'h01;

        // reset state (out_ready_a low: in_ready must still be 1)
        #2;
        check("rst_out_valid_a", {31'b0, out_valid_a}, 32'd0);
        check("rst_out_idx_a", {29'b0, out_idx_a}, 32'd0);
        check("rst_out_none_a", {31'b0, out_none_a}, 32'd0);
        check("rst_out_multi_a", {31'b0, out_multi_a}, 32'd0);
        check("rst_in_ready_a", {31'b0, in_ready_a}, 32'd1);
        check("rst_out_valid_b", {31'b0, out_valid_b}, 32'd0);
        check("rst_out_valid_c", {31'b0, out_valid_c}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready_a = 1'b1;
        idle(1);

        // fixed mode: one-hot sweep, multi-hot, zero
        for (int i = 0; i < 8; i++) send(0, one << i, {2'b00, 3'(i)});
        send(0, 8'b00001100, 5'b01_010);
        send(0, 8'b00000000, 5'b10_000);
        send(0, 8'b10000101, 5'b01_000);
        send(0, 8'b11111111, 5'b01_000);
        idle(2);

        // backpressure: hold a result for 3 cycles, ignore in_req while stalled
        out_ready_a = 1'b0;
        send(0, 8'b00010000, 5'b00_100);
        in_valid_a = 1'b1;
        in_req_a   = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", {31'b0, in_ready_a}, 32'd0);
            check("bp_out_valid", {31'b0, out_valid_a}, 32'd1);
            check("bp_hold", {27'b0, out_none_a, out_multi_a, out_idx_a}, 32'b00_100);
            @(posedge clk);
            #1;
            in_req_a = 8'h0F;
        end
        out_ready_a = 1'b1;
        c0 = cyc;
        send(0, 8'b01000000, 5'b00_110);
        send(0, 8'b00100000, 5'b00_101);
        send(0, 8'b00000011, 5'b01_000);
        send(0, 8'b10000000, 5'b00_111);
        check("no_bubble_cycles", 32'(cyc - c0), 32'd4);
        idle(2);

        // round-robin N=8: 0, 2, 7 (wrap), 0
        send(1, 8'b10000101, 5'b01_000);
        send(1, 8'b10000101, 5'b01_010);
        send(1, 8'b10000101, 5'b01_111);
        send(1, 8'b10000101, 5'b01_000);
        send(1, 8'b00000000, 5'b10_000);
        send(1, 8'b00000110, 5'b01_001);
        idle(1);

        // leave a held result with ptr=3, then reset between edges
        out_ready_b = 1'b0;
        send(1, 8'b00000110, 5'b01_010);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid_b", {31'b0, out_valid_b}, 32'd0);
        check("midrst_out_idx_b", {29'b0, out_idx_b}, 32'd0);
        check("midrst_in_ready_b", {31'b0, in_ready_b}, 32'd1);
        exp_b.delete();
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        out_ready_b = 1'b1;
        idle(1);
        send(1, 8'b00001001, 5'b01_000);
        idle(2);

        // round-robin N=5: 0, 4 (wrap), 0, then mixed
        send(2, 8'b00010001, 5'b01_000);
        send(2, 8'b00010001, 5'b01_100);
        send(2, 8'b00010001, 5'b01_000);
        send(2, 8'b00000110, 5'b01_001);
        send(2, 8'b00000001, 5'b00_000);
        idle(3);

        check("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b.size()), 32'd0);
        check("c_queue_drained", 32'(exp_c.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised, registered N-to-log2(N) priority encoder with valid/ready handshakes and a selectable fixed-priority or round-robin search mode. It generalises the 8-to-3 one-hot encoder to any width. It reports multi-hot and all-zero inputs explicitly instead of leaving them undefined. It sits between request sources (interrupt lines, channel-ready vectors) and any consumer needing a single index per transaction.

## Interface
- `N`, 8: number of request bits; legal range 2..256.
- `RR_MODE`, 0: 0 = fixed priority (bit 0 highest); 1 = round-robin starting from the rotating pointer.
- `W`, `$clog2(N)`: index width; localparam, not overridable.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request vector is presented.
- `in_req`  in  N  request vector; any bit pattern is legal.
- `in_ready`  out  1  block can accept `in_req` this cycle.
- `out_valid`  out  1  output register holds a result.
- `out_ready`  in  1  consumer takes the result this cycle.
- `out_idx`  out  W  index of the selected bit.
- `out_none`  out  1  accepted vector was all zeros.
- `out_multi`  out  1  accepted vector had more than one bit set.

## Operation
- Transfer in: occurs when `in_valid && in_ready`. Transfer out: occurs when `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is a single output register with pass-through backpressure. It is combinational from `out_ready`; there is no combinational path from `in_valid`.
- On a transfer in, the output register loads a new result and `out_valid` is set to 1.
- On a transfer out with no transfer in, `out_valid` is cleared to 0.
- While `out_valid=1 && !out_ready`, `out_idx`, `out_none` and `out_multi` are held stable.
- Fixed mode: `out_idx` = lowest set index of `in_req`.
- Round-robin mode: search `ptr, ptr+1, …, N-1, 0, …, ptr-1`; `out_idx` = first set index found.
- `ptr` update (round-robin mode only): on a transfer in with a nonzero vector, `ptr` becomes `(out_idx+1) mod N`. When the selected index is N-1, `ptr` wraps to 0.
- `ptr` is left unchanged on an all-zero vector and in fixed mode.
- All-zero vector: `out_none=1`, `out_idx=0`, `out_multi=0`.
- Multi-hot flag: `out_multi = (popcount(in_req) > 1)`, computed on the accepted vector.
- For a one-hot vector with bit i set: `out_idx=i`, `out_none=0`, `out_multi=0` in both modes. This matches the legacy 8-to-3 behaviour for `N=8`.
- When N is not a power of two, `out_idx` never exceeds N-1.

## Timing
- Reset values (asynchronous, applied immediately): `out_valid=0`, `out_idx=0`, `out_none=0`, `out_multi=0`, `ptr=0`.
- While in reset, `in_ready=1` because `out_valid=0`.
- Latency: the result is visible one cycle after the accepting edge.
- Throughput: 1 result/cycle when `out_ready` is held high.
- Simultaneous transfer in and out in the same cycle: the register reloads and `out_valid` stays 1; no bubble is inserted.
- Reset asserted mid-transaction discards the held result and resets `ptr`. After deassertion, the first accepted vector is searched from index 0.
- `in_req` is sampled only on a transfer in. Changes while `in_ready=0` are ignored.

## Structure
- Package `enc_pkg`:
  - `mode_e` enum (`ENC_FIXED`, `ENC_RR`);
  - function `popcount_gt1`;
  - function computing the lowest set index of a rotated vector, width-generic via a parameterised class or generic function.
- Sub-module `prio_search` (combinational):
  - Inputs: `req[N-1:0]`, `start[W-1:0]`.
  - Outputs: `idx[W-1:0]`, `none`.
  - Method: rotate `req` right by `start`, find the lowest set bit, add `start` mod N.
  - Fixed mode drives `start=0`.
- Top level holds `ptr`, the output register and the handshake logic.

## Test plan
- One-hot sweep, `N=8`, fixed mode, `out_ready=1`: `in_req=8'b1<<i` for i=0..7 → `out_idx=i` one cycle later, `out_none=0`, `out_multi=0`.
- Multi-hot and zero, fixed mode: `8'b00001100` → `out_idx=2`, `out_multi=1`; `8'b00000000` → `out_none=1`, `out_idx=0`.
- Round-robin, `N=8`, `in_req=8'b10000101` held for 4 transfers → `out_idx` sequence 0, 2, 7, 0, confirming the wrap at N-1.
- Backpressure: `out_ready=0` for 3 cycles after a transfer in → `in_ready=0`, outputs stable. Then `out_ready=1` with `in_valid=1` → back-to-back results with no bubble.
- Non-power-of-2, `N=5`, round-robin, `in_req=5'b10001` repeated → `out_idx` 0, 4, 0; never ≥5.
- Mid-operation reset: round-robin with `ptr=3` and `out_valid=1`, assert `rst` between edges → `out_valid=0` immediately. After release, `8'b00001001` gives `out_idx=0`.
